// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch-side memory blocks of the RISC-V core.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Canonical NOP: addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// Word-wide instruction storage: one write port, one registered read port.
// A read and a write to the same word on the same edge return the old word.
module imem_array
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;

  // Storage write and registered read; non-blocking order gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage: one outstanding request,
// fixed LATENCY, separate load port for program words.
// Optional feature macro: IMEM_BOUNDS_CHECK_EN (address fault reporting,
// NOP substitution and out-of-range load suppression).
module imem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_addr,
  input  logic [XLEN-1:0] load_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CntInit = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  imem_state_t     state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            rd_pend_q, rd_pend_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;

  logic            accept;
  logic            req_bad;
  logic            load_we;
  logic [XLEN-1:0] arr_rdata;

`ifdef IMEM_BOUNDS_CHECK_EN
  assign req_bad = (req_addr[1:0] != 2'b00) || (req_addr[XLEN-1:AW+2] != '0);
  assign load_we = load_en && (load_addr[XLEN-1:AW+2] == '0);
  logic unused_load_lsb;
  assign unused_load_lsb = ^load_addr[1:0];
`else
  // Addresses wrap modulo the array size; byte offset is ignored.
  assign req_bad = 1'b0;
  assign load_we = load_en;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[XLEN-1:AW+2], req_addr[1:0],
                              load_addr[XLEN-1:AW+2], load_addr[1:0]};
`endif

  // Ready depends only on state (and reset), never on rsp_ready.
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;

  // The array output is only valid the cycle after the read; afterwards data_q holds it.
  assign rsp_data = err_q ? NOP_INSTR : (rd_pend_q ? arr_rdata : data_q);

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (load_we),
    .waddr(load_addr[AW+1:2]),
    .wdata(load_data),
    .re   (accept),
    .raddr(req_addr[AW+1:2]),
    .rdata(arr_rdata)
  );

  // Next-state logic for the request/response FSM and its latency counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_pend_d = accept;
    data_d    = rd_pend_q ? arr_rdata : data_q;
    err_d     = accept ? req_bad : err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CntInit;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset drops any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      rd_pend_q <= 1'b0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: two instances (LATENCY 1 and 3) share
// all inputs; expected words come from a bench-side memory model.
module tb_imem_responder;

  localparam int unsigned Depth = 256;
  localparam int unsigned Lat0  = 1;
  localparam int unsigned Lat1  = 3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic [1:0]       rdy;
  logic [1:0]       vld;
  logic [1:0]       err;
  logic [1:0][31:0] dat;

  imem_responder #(.DEPTH_WORDS(Depth), .LATENCY(Lat0)) u_dut_l1 (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(rdy[0]),
    .req_addr (req_addr),
    .rsp_valid(vld[0]),
    .rsp_ready(rsp_ready),
    .rsp_data (dat[0]),
    .rsp_err  (err[0]),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  imem_responder #(.DEPTH_WORDS(Depth), .LATENCY(Lat1)) u_dut_l3 (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(rdy[1]),
    .req_addr (req_addr),
    .rsp_valid(vld[1]),
    .rsp_ready(rsp_ready),
    .rsp_data (dat[1]),
    .rsp_err  (err[1]),
    .load_en  (load_en),
    .load_addr(load_addr),
    .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        err;
    int          acc;
    bit          seen;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_model [Depth];
  int          cyc;
  int          n_checks;
  int          n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, want %08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [32:0] model_rd(input logic [31:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
    if (a[1:0] != 2'b00 || a >= 32'(4 * Depth)) return {1'b1, 32'h0000_0013};
`endif
    return {1'b0, mem_model[a[9:2]]};
  endfunction

  function automatic int head(input int id);
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].id == id) return k;
    end
    return -1;
  endfunction

  // One clock cycle: score outputs, record acceptances, update the model.
  task automatic tick();
    int          h;
    exp_t        e;
    logic [32:0] rd;
    #1;
    for (int i = 0; i < 2; i++) begin
      h = head(i);
      if (rst) check($sformatf("rdy_in_rst%0d", i), 32'(rdy[i]), 32'd0);
      if (vld[i] === 1'b1) begin
        if (h < 0) begin
          check($sformatf("spurious_rsp%0d", i), 32'(vld[i]), 32'd0);
        end else begin
          if (!sb[h].seen) begin
            check($sformatf("latency%0d", i), 32'(cyc - sb[h].acc),
                  (i == 0) ? 32'(Lat0) : 32'(Lat1));
            sb[h].seen = 1'b1;
          end
          check($sformatf("data%0d", i), dat[i], sb[h].data);
          check($sformatf("err%0d", i), 32'(err[i]), 32'(sb[h].err));
          check($sformatf("rdy_in_resp%0d", i), 32'(rdy[i]), 32'd0);
          if (rsp_ready) sb.delete(h);
        end
      end
      if (req_valid && rdy[i] === 1'b1) begin
        rd     = model_rd(req_addr);
        e.id   = i;
        e.err  = rd[32];
        e.data = rd[31:0];
        e.acc  = cyc;
        e.seen = 1'b0;
        sb.push_back(e);
      end
    end
    // Model write after the reads above: read-before-write.
    if (load_en) begin
`ifdef IMEM_BOUNDS_CHECK_EN
      if (load_addr < 32'(4 * Depth)) mem_model[load_addr[9:2]] = load_data;
`else
      mem_model[load_addr[9:2]] = load_data;
`endif
    end
    if (rst) sb.delete();
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a);
    int n;
    n = 0;
    while (rdy !== 2'b11 && n < 50) begin
      tick();
      n++;
    end
    if (rdy !== 2'b11) check("req_wait_timeout", 32'(rdy), 32'd3);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || rdy !== 2'b11) && n < 50) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_valid", 32'(vld), 32'd0);
    check("reset_data0", dat[0], 32'd0);
    check("reset_data1", dat[1], 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_ready", 32'(rdy), 32'd3);

    do_load(32'h0000_0000, 32'hCAFE_0001);
    do_load(32'h0000_0004, 32'h1111_1111);
    do_load(32'h0000_000C, 32'h0050_0093);
    do_load(32'h0000_03FC, 32'h0FF0_0FF0);

    // Basic fetch.
    do_req(32'h0000_000C);
    wait_idle();

    // Load during the wait window must not disturb the pending response.
    do_req(32'h0000_000C);
    do_load(32'h0000_000C, 32'h1234_5678);
    wait_idle();
    do_req(32'h0000_000C);
    wait_idle();

    // Backpressure: both instances sit in RESP with outputs frozen.
    rsp_ready = 1'b0;
    do_req(32'h0000_000C);
    repeat (8) tick();
    rsp_ready = 1'b1;
    tick();
    #1;
    check("rdy_after_release", 32'(rdy), 32'd3);
    check("valid_after_release", 32'(vld), 32'd0);
    wait_idle();

    // Address boundaries, misalignment and out-of-range loads.
    do_req(32'h0000_03FC);
    wait_idle();
    do_req(32'h0000_0400);
    wait_idle();
    do_req(32'h0000_000E);
    wait_idle();
    do_load(32'h0000_0404, 32'h5555_0000);
    do_req(32'h0000_0004);
    wait_idle();

    // Reset while the LATENCY=3 instance is in WAIT.
    rsp_ready = 1'b0;
    do_req(32'h0000_000C);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(vld), 32'd0);
    check("midrst_data0", dat[0], 32'd0);
    check("midrst_data1", dat[1], 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    rsp_ready = 1'b1;
    repeat (6) tick();
    do_req(32'h0000_000C);
    wait_idle();

    // Same-cycle load and accept to word 5.
    do_load(32'h0000_0014, 32'hAAAA_AAAA);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0014;
    load_en   = 1'b1;
    load_addr = 32'h0000_0014;
    load_data = 32'hBBBB_BBBB;
    tick();
    req_valid = 1'b0;
    load_en   = 1'b0;
    wait_idle();
    do_req(32'h0000_0014);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
